// File: rtl/wb_stage_if.sv
// Upstream retire handshake into the writeback stage: one retiring instruction per accept.
interface wb_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [1:0]  in_wsel;
    logic [31:0] in_alu;
    logic [31:0] in_pc4;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;

    modport master (
        output in_valid, in_rd, in_wsel, in_alu, in_pc4, in_funct3, in_addr_lo,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd, in_wsel, in_alu, in_pc4, in_funct3, in_addr_lo,
        output in_ready
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU/link results in one cycle and waits for the data memory on loads,
// extracting and sign/zero-extending the loaded byte, halfword or word before the register file write.
module wb_stage (
    input  logic        clk,
    input  logic        clrn,
    wb_stage_if.slave   up,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rf_d,
    output logic [4:0]  rf_wn,
    output logic        rf_we,
    output logic [31:0] retired
);
    typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

    localparam logic [1:0] WSEL_LOAD = 2'b01;
    localparam logic [1:0] WSEL_LINK = 2'b10;
    localparam logic [1:0] WSEL_NONE = 2'b11;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_ld_rd;
    logic [2:0]  r_ld_funct3;
    logic [1:0]  r_ld_addr_lo;
    logic [31:0] r_rf_d;
    logic [4:0]  r_rf_wn;
    logic        r_rf_we;
    logic [31:0] r_retired;

    logic        w_ld_accept;
    logic        w_complete;
    logic        w_wr_en;
    logic [31:0] w_wr_data;
    logic [4:0]  w_wr_addr;

    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b100:  load_extract = {24'd0, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b101:  load_extract = {16'd0, h};
            default: load_extract = word;
        endcase
    endfunction

    assign up.in_ready = (r_state == S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_ld_accept = 1'b0;
        w_complete  = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_data   = '0;
        w_wr_addr   = '0;
        case (r_state)
            S_IDLE: begin
                if (up.in_valid) begin
                    if (up.in_wsel == WSEL_LOAD) begin
                        w_ld_accept = 1'b1;
                        w_state_nxt = S_WAIT_MEM;
                    end else begin
                        w_complete = 1'b1;
                        w_wr_en    = (up.in_wsel != WSEL_NONE) && (up.in_rd != 5'd0);
                        w_wr_addr  = up.in_rd;
                        w_wr_data  = (up.in_wsel == WSEL_LINK) ? up.in_pc4 : up.in_alu;
                    end
                end
            end
            S_WAIT_MEM: begin
                // Responses are only meaningful here; a stray mem_rvalid in IDLE never reaches this path.
                if (mem_rvalid) begin
                    w_state_nxt = S_IDLE;
                    w_complete  = 1'b1;
                    w_wr_en     = (r_ld_rd != 5'd0);
                    w_wr_addr   = r_ld_rd;
                    w_wr_data   = load_extract(r_ld_funct3, r_ld_addr_lo, mem_rdata);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ld_rd      <= '0;
            r_ld_funct3  <= '0;
            r_ld_addr_lo <= '0;
        end else if (w_ld_accept) begin
            r_ld_rd      <= up.in_rd;
            r_ld_funct3  <= up.in_funct3;
            r_ld_addr_lo <= up.in_addr_lo;
        end
    end

    // Write data/address only move on a write, so they hold between pulses.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_rf_we   <= 1'b0;
            r_rf_d    <= '0;
            r_rf_wn   <= '0;
            r_retired <= '0;
        end else begin
            r_rf_we <= w_wr_en;
            if (w_wr_en) begin
                r_rf_d  <= w_wr_data;
                r_rf_wn <= w_wr_addr;
            end
            if (w_complete) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign rf_d    = r_rf_d;
    assign rf_wn   = r_rf_wn;
    assign rf_we   = r_rf_we;
    assign retired = r_retired;
endmodule
